// File: rtl/pps_period_capture.sv
// pps_period_capture: measures the period of an async pulse on s_in in clk cycles
// and offers each captured period through a valid/ack handshake.
// Optional timeout disarm is enabled by defining PPS_TIMEOUT_EN.
module pps_period_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             ack,
  output logic             outp,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             ovf,
  output logic             missed,
  output logic             armed,
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] TO_LAST = WIDTH'(TIMEOUT - 1);
`ifdef PPS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  // Without the timeout feature the compare is constant-false and folds away.
  localparam bit TO_EN = 1'b0;
`endif

  state_t                 state;
  state_t                 next_state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   rise;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       cnt_next;
  logic [WIDTH-1:0]       cap_val;
  logic                   cap_ovf;
  logic                   capture;
  logic                   to_hit;
  logic                   to_fire;

  // Rising edge of the synchronised input; one cycle wide by construction.
  assign rise   = sync[SYNC_STAGES-1] & ~sync_prev;
  assign to_hit = TO_EN && (state == ARMED) && (cnt == TO_LAST);
  assign armed  = (state == ARMED);

  // Synchroniser chain plus one extra flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], s_in};
      sync_prev <= sync[SYNC_STAGES-1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state: first edge arms; a silent timeout (edge has priority) disarms.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (rise) next_state = ARMED;
      ARMED:   if (!rise && to_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decode: capture strobe, saturating capture value and next counter value.
  always_comb begin
    capture  = (state == ARMED) && rise;
    to_fire  = to_hit && !rise;
    cap_ovf  = (cnt == CNT_MAX);
    cap_val  = cap_ovf ? CNT_MAX : cnt + WIDTH'(1);
    cnt_next = cnt;
    if (state == IDLE || rise || to_fire) cnt_next = '0;
    else if (cnt != CNT_MAX)              cnt_next = cnt + WIDTH'(1);
  end

  // Counter, capture register, handshake and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      outp     <= 1'b0;
      data_out <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      missed   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      outp <= rise;
      if (capture) begin
        data_out <= cap_val;
        ovf      <= cap_ovf;
        valid    <= 1'b1;
        // Overwriting an unconsumed word is recorded unless it is being taken now.
        if (valid && !ack) missed <= 1'b1;
      end else if (ack && valid) begin
        valid <= 1'b0;
      end
      if (to_fire) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pps_period_capture.sv
// Bench for pps_period_capture: a 32-bit and an 8-bit instance share stimulus;
// directed table/sequences plus randomized pulses against a period-arithmetic model.
module tb_pps_period_capture;

  localparam int S    = 2;
  localparam int TO32 = 500;
  localparam int TO8  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_in = 1'b0;
  logic        ack = 1'b0;
  logic        outp32, valid32, ovf32, missed32, armed32, timeout32;
  logic [31:0] data32;
  logic        outp8, valid8, ovf8, missed8, armed8, timeout8;
  logic [7:0]  data8;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pps_period_capture #(.WIDTH(32), .SYNC_STAGES(S), .TIMEOUT(TO32)) dut32 (
    .clk(clk), .reset(reset), .s_in(s_in), .ack(ack), .outp(outp32),
    .data_out(data32), .valid(valid32), .ovf(ovf32), .missed(missed32),
    .armed(armed32), .timeout(timeout32));

  pps_period_capture #(.WIDTH(8), .SYNC_STAGES(S), .TIMEOUT(TO8)) dut8 (
    .clk(clk), .reset(reset), .s_in(s_in), .ack(ack), .outp(outp8),
    .data_out(data8), .valid(valid8), .ovf(ovf8), .missed(missed8),
    .armed(armed8), .timeout(timeout8));

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works on the history of sampled s_in values and absolute edge times:
  // the period is simply the distance between consecutive detected edges.
  bit  smp[$];
  bit  m_outp;
  bit  m_armed[2], m_valid[2], m_missed[2], m_timeout[2];
  int  m_last[2], m_period[2];

  function automatic longint max_of(input int i);
    return (i == 0) ? 64'hFFFF_FFFF : 64'd255;
  endfunction

  function automatic longint exp_data(input int i);
    return (longint'(m_period[i]) > max_of(i)) ? max_of(i) : longint'(m_period[i]);
  endfunction

  function automatic longint exp_ovf(input int i);
    return (longint'(m_period[i]) > max_of(i)) ? 64'd1 : 64'd0;
  endfunction

`ifdef PPS_TIMEOUT_EN
  function automatic int to_of(input int i);
    return (i == 0) ? TO32 : TO8;
  endfunction
`endif

  always @(posedge clk or posedge reset) begin : model
    int n;
    bit cur, prv, r;
    if (reset) begin
      smp.delete();
      m_outp = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_armed[i] = 0; m_valid[i] = 0; m_missed[i] = 0; m_timeout[i] = 0;
        m_last[i] = 0; m_period[i] = 0;
      end
    end else begin
      n   = smp.size();
      // An edge is seen S posedges after s_in is first sampled high.
      cur = (n >= S)     ? smp[n-S]   : 1'b0;
      prv = (n >= S + 1) ? smp[n-S-1] : 1'b0;
      r   = cur & ~prv;
      m_outp = r;
      for (int i = 0; i < 2; i++) begin
        if (r) begin
          if (m_armed[i]) begin
            m_period[i] = n - m_last[i];
            if (m_valid[i] && !ack) m_missed[i] = 1'b1;
            m_valid[i] = 1'b1;
          end else begin
            m_armed[i] = 1'b1;
          end
          m_last[i] = n;
        end else begin
          if (ack && m_valid[i]) m_valid[i] = 1'b0;
`ifdef PPS_TIMEOUT_EN
          if (m_armed[i] && (n - m_last[i] == to_of(i))) begin
            m_armed[i]   = 1'b0;
            m_timeout[i] = 1'b1;
          end
`endif
        end
      end
      smp.push_back(s_in);
    end
  end

  // Continuous comparison against the model, well away from the posedge.
  always @(negedge clk) begin
    #2;
    if (chk_on && !reset) begin
      check("outp32",    outp32,    m_outp);
      check("valid32",   valid32,   m_valid[0]);
      check("missed32",  missed32,  m_missed[0]);
      check("armed32",   armed32,   m_armed[0]);
      check("timeout32", timeout32, m_timeout[0]);
      if (m_valid[0]) begin
        check("data32", data32, exp_data(0));
        check("ovf32",  ovf32,  exp_ovf(0));
      end
      check("outp8",    outp8,    m_outp);
      check("valid8",   valid8,   m_valid[1]);
      check("missed8",  missed8,  m_missed[1]);
      check("armed8",   armed8,   m_armed[1]);
      check("timeout8", timeout8, m_timeout[1]);
      if (m_valid[1]) begin
        check("data8", data8, exp_data(1));
        check("ovf8",  ovf8,  exp_ovf(1));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; s_in = 1'b0; ack = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  // Rising edge now; returns once the resulting capture is visible.
  task automatic pulse();
    s_in = 1'b1;
    tick(3);
    s_in = 1'b0;
  endtask

  task automatic check_zero32(input string tag);
    check({tag, "_outp"},    outp32,    0);
    check({tag, "_valid"},   valid32,   0);
    check({tag, "_data"},    data32,    0);
    check({tag, "_ovf"},     ovf32,     0);
    check({tag, "_missed"},  missed32,  0);
    check({tag, "_armed"},   armed32,   0);
    check({tag, "_timeout"}, timeout32, 0);
  endtask

  typedef struct {
    int     gap;       // cycles from previous rising edge (0: first pulse)
    bit     ack_first; // acknowledge the pending word early in the gap
    bit     valid;
    bit     armed;
    longint d32;
    longint d8;
    bit     o8;
    bit     missed;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{gap: 0,    ack_first: 0, valid: 0, armed: 1, d32: 0,    d8: 0,   o8: 0, missed: 0};
    tbl[1] = '{gap: 1000, ack_first: 0, valid: 1, armed: 1, d32: 1000, d8: 255, o8: 1, missed: 0};
    tbl[2] = '{gap: 1000, ack_first: 1, valid: 1, armed: 1, d32: 1000, d8: 255, o8: 1, missed: 0};
    tbl[3] = '{gap: 50,   ack_first: 0, valid: 1, armed: 1, d32: 50,   d8: 50,  o8: 0, missed: 1};
    tbl[4] = '{gap: 255,  ack_first: 1, valid: 1, armed: 1, d32: 255,  d8: 255, o8: 0, missed: 1};
    tbl[5] = '{gap: 256,  ack_first: 1, valid: 1, armed: 1, d32: 256,  d8: 255, o8: 1, missed: 1};
    tbl[6] = '{gap: 300,  ack_first: 0, valid: 1, armed: 1, d32: 300,  d8: 255, o8: 1, missed: 1};

    // Reset state while reset is held.
    tick(1);
    check_zero32("rst");
    check("rst_valid8", valid8, 0);
    check("rst_data8",  data8,  0);
    do_reset();
    chk_on = 1'b1;

`ifndef PPS_TIMEOUT_EN
    // Table: pulse trains with assorted gaps and ack placement.
    for (int v = 0; v < 7; v++) begin
      if (tbl[v].gap > 0) begin
        if (tbl[v].ack_first) begin
          ack = 1'b1; tick(1); ack = 1'b0;
          tick(tbl[v].gap - 4);
        end else begin
          tick(tbl[v].gap - 3);
        end
      end
      pulse();
      check($sformatf("tbl%0d_valid32", v),  valid32,  tbl[v].valid);
      check($sformatf("tbl%0d_armed32", v),  armed32,  tbl[v].armed);
      check($sformatf("tbl%0d_missed32", v), missed32, tbl[v].missed);
      check($sformatf("tbl%0d_valid8", v),   valid8,   tbl[v].valid);
      if (tbl[v].valid) begin
        check($sformatf("tbl%0d_data32", v), data32, tbl[v].d32);
        check($sformatf("tbl%0d_ovf32", v),  ovf32,  0);
        check($sformatf("tbl%0d_data8", v),  data8,  tbl[v].d8);
        check($sformatf("tbl%0d_ovf8", v),   ovf8,   tbl[v].o8);
      end
    end
    // A single ack clears the overwritten word.
    ack = 1'b1; tick(1); ack = 1'b0;
    check("tbl_ack_clears_valid", valid32, 0);

    // Reset 400 cycles into a 1000-cycle period.
    do_reset();
    pulse();
    tick(397);
    reset = 1'b1;
    tick(1);
    check_zero32("midrst");
    reset = 1'b0;
    tick(599);
    pulse();
    check("midrst_rearm_armed", armed32, 1);
    check("midrst_rearm_valid", valid32, 0);
    tick(997);
    pulse();
    check("midrst_period_valid", valid32, 1);
    check("midrst_period_data",  data32,  1000);
`endif

    // Ack on the exact capture cycle, plus output-pulse latency.
    do_reset();
    pulse();
    tick(97);
    pulse();
    check("ae_first_data", data32, 100);
    tick(57);
    s_in = 1'b1;
    tick(1); check("lat_outp_c1", outp32, 0);
    tick(1); check("lat_outp_c2", outp32, 0);
    ack = 1'b1;
    tick(1); check("lat_outp_c3", outp32, 1);
    ack = 1'b0; s_in = 1'b0;
    check("ae_valid",  valid32,  1);
    check("ae_data",   data32,   60);
    check("ae_missed", missed32, 0);
    tick(1); check("lat_outp_c4", outp32, 0);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("ae_ack_clears", valid32, 0);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("ae_idle_ack_valid",  valid32,  0);
    check("ae_idle_ack_missed", missed32, 0);

`ifdef PPS_TIMEOUT_EN
    // Edge then silence: disarm exactly TIMEOUT cycles after the edge.
    do_reset();
    pulse();
    tick(TO32 - 1);
    check("to_before_armed",   armed32,   1);
    check("to_before_timeout", timeout32, 0);
    tick(1);
    check("to_armed",   armed32,   0);
    check("to_timeout", timeout32, 1);
    tick(50);
    pulse();
    check("to_rearm_armed",   armed32,   1);
    check("to_rearm_valid",   valid32,   0);
    check("to_rearm_timeout", timeout32, 1);
`endif

    // Randomized pulse trains with random acks, checked by the model.
    do_reset();
    repeat (60) begin
      int g;
      g = $urandom_range(4, 400);
      for (int j = 0; j < g; j++) begin
        s_in = (j < 3);
        ack  = ($urandom_range(0, 7) == 0);
        tick(1);
      end
    end
    s_in = 1'b0; ack = 1'b0;
    tick(5);
    chk_on = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
